// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard scheduler.
//  - schedState_t : scheduler FSM states
//  - SB_*         : scoreboard stage indices (EX is the youngest in-flight entry)
//  - REG_ZERO/RA  : architectural register numbers with special meaning
//  - sbEntry_t    : one scoreboard slot {valid, destination}
//  - entryHit     : true when a slot holds a live write to a non-zero register r
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } schedState_t;

  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic       v;
    logic [4:0] addr;
  } sbEntry_t;

  function automatic logic entryHit(input sbEntry_t e, input logic [4:0] r);
    return e.v && (e.addr == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard for the EX, MEM and WB stages.
//  clk, rst          : pipeline clock, asynchronous active-low reset
//  shift_en          : advance the scoreboard one stage (low while the pipe is frozen)
//  push_v, push_addr : destination entering EX on a shift
//  rs, rt            : source registers of the instruction in ID
//  hit_rs, hit_rt    : that source is still being produced by an in-flight instruction
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       push_v,
  input  logic [4:0] push_addr,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hit_rs,
  output logic       hit_rt
);

  sbEntry_t                sbReg [SB_DEPTH];
  logic     [SB_DEPTH-1:0] rsHitVec;
  logic     [SB_DEPTH-1:0] rtHitVec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sbReg[i] <= '0;
      end
    end else if (shift_en) begin
      // $0 is never a real dependency, so it is entered as an empty slot.
      sbReg[SB_EX]  <= '{v: push_v && (push_addr != REG_ZERO), addr: push_addr};
      sbReg[SB_MEM] <= sbReg[SB_EX];
      sbReg[SB_WB]  <= sbReg[SB_MEM];
    end
  end

  // With a write-through regfile the WB result is readable in the same cycle,
  // so the WB slot only participates when that bypass is absent.
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_hit
    localparam bit SLOT_VISIBLE = (gi != SB_WB) || !WB_BYPASS;
    assign rsHitVec[gi] = SLOT_VISIBLE && entryHit(sbReg[gi], rs);
    assign rtHitVec[gi] = SLOT_VISIBLE && entryHit(sbReg[gi], rt);
  end

  assign hit_rs = |rsHitVec;
  assign hit_rt = |rtHitVec;

endmodule

// File: rtl/pipeline_hazard_sched.sv
// Decode-stage hazard scheduler for the 5-stage pipeline.
// Stalls ID on RAW hazards (no forwarding into decode), squashes the wrong-path
// fetch on a taken redirect and freezes EX/MEM/WB while memory is not ready,
// aborting a wait after MEM_TIMEOUT cycles.
//  clk, rst              : pipeline clock, asynchronous active-low reset
//  id_*                  : description of the instruction currently in ID
//  mem_access, MIO_ready : MEM-stage load/store and memory handshake
//  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, redirect_en, pipe_freeze
//                        : combinational pipeline controls (zero latency)
//  mem_timeout_err       : sticky flag, a memory wait was aborted
//  stall_cycles          : saturating count of cycles with pc_write_en low
module pipeline_hazard_sched
  import pipeline_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS   = 1'b1,
  parameter bit DELAY_SLOT  = 1'b0,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_useRs,
  input  logic        id_useRt,
  input  logic        id_writeReg,
  input  logic [4:0]  id_writeAddr,
  input  logic        id_jumpOrBranch,
  input  logic        mem_access,
  input  logic        MIO_ready,
  output logic        pc_write_en,
  output logic        ifid_write_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        redirect_en,
  output logic        pipe_freeze,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cycles
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  schedState_t stateReg;
  logic [7:0]  waitCntReg;
  logic        timeoutErrReg;
  logic [31:0] stallCntReg;
  logic        idKilledReg;

  logic hitRs;
  logic hitRt;
  logic freeze;
  logic raw;
  logic advance;
  logic redirect;
  logic pushValid;

  // The cycle MIO_ready returns completes the access, so the pipe already moves
  // on that cycle; freeze covers only cycles where memory is actually not ready.
  assign freeze   = !MIO_ready && ((stateReg == MEM_WAIT) || mem_access);
  assign raw      = id_valid && ((id_useRs && hitRs) || (id_useRt && hitRt));
  assign advance  = !freeze && !raw;
  // A branch whose operands are still in flight waits for them before redirecting.
  assign redirect = advance && id_valid && id_jumpOrBranch;

  assign pipe_freeze     = freeze;
  assign pc_write_en     = advance;
  assign ifid_write_en   = advance;
  assign idex_bubble     = raw && !freeze;
  assign redirect_en     = redirect;
  assign ifid_flush      = redirect && !DELAY_SLOT;
  assign mem_timeout_err = timeoutErrReg;
  assign stall_cycles    = stallCntReg;

  // A stalled instruction re-enters ID next cycle, so it must not be recorded
  // yet; neither may a wrong-path instruction that was squashed in IF/ID.
  assign pushValid = id_valid && id_writeReg && !raw && !idKilledReg;

  hazard_scoreboard #(
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (!freeze),
    .push_v    (pushValid),
    .push_addr (id_writeAddr),
    .rs        (id_rs),
    .rt        (id_rt),
    .hit_rs    (hitRs),
    .hit_rt    (hitRt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg      <= RUN;
      waitCntReg    <= '0;
      timeoutErrReg <= 1'b0;
    end else begin
      case (stateReg)
        RUN: begin
          if (mem_access && !MIO_ready) begin
            stateReg   <= MEM_WAIT;
            waitCntReg <= '0;
          end
        end
        MEM_WAIT: begin
          // Ready on the final allowed cycle still counts as a successful access.
          if (MIO_ready) begin
            stateReg <= RUN;
          end else if (waitCntReg == WAIT_LAST) begin
            stateReg      <= RUN;
            timeoutErrReg <= 1'b1;
          end else begin
            waitCntReg <= waitCntReg + 8'd1;
          end
        end
        default: stateReg <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCntReg <= '0;
      idKilledReg <= 1'b0;
    end else begin
      if (!advance && (stallCntReg != 32'hFFFF_FFFF)) begin
        stallCntReg <= stallCntReg + 32'd1;
      end
      // Tracks whether the IF/ID contents were loaded as a squashed slot.
      if (advance) begin
        idKilledReg <= ifid_flush;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sched.sv
module tb_pipeline_hazard_sched;
  import pipeline_ctrl_pkg::*;

  localparam bit WB_BYPASS   = 1'b1;
  localparam bit DELAY_SLOT  = 1'b0;
  localparam int MEM_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_useRs, id_useRt, id_writeReg, id_jumpOrBranch;
  logic [4:0]  id_rs, id_rt, id_writeAddr;
  logic        mem_access, MIO_ready;
  logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
  logic        redirect_en, pipe_freeze, mem_timeout_err;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_sched #(
    .WB_BYPASS   (WB_BYPASS),
    .DELAY_SLOT  (DELAY_SLOT),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_useRs        (id_useRs),
    .id_useRt        (id_useRt),
    .id_writeReg     (id_writeReg),
    .id_writeAddr    (id_writeAddr),
    .id_jumpOrBranch (id_jumpOrBranch),
    .mem_access      (mem_access),
    .MIO_ready       (MIO_ready),
    .pc_write_en     (pc_write_en),
    .ifid_write_en   (ifid_write_en),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .redirect_en     (redirect_en),
    .pipe_freeze     (pipe_freeze),
    .mem_timeout_err (mem_timeout_err),
    .stall_cycles    (stall_cycles)
  );

  int vectors     = 0;
  int miscompares = 0;
  int checks      = 0;

  // Reference model: list of destinations still in flight, youngest first
  // (-1 = no register). Index 0 is one instruction ahead, 1 two ahead, etc.
  int     inFlight [3];
  bit     mWaiting, mErr, mKilled;
  int     mWaited;
  longint mStalls;
  bit     eFreeze, eRaw, eGo, eRed, eFlush, eBub;

  // Last observed DUT outputs (sampled 1ns after the inputs settle)
  logic        oPf, oPc, oIfw, oFl, oBub, oRed, oErr;
  logic [31:0] oStall;

  function automatic bit producing(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (inFlight[0] == int'(r) || inFlight[1] == int'(r)) return 1'b1;
    return !WB_BYPASS && inFlight[2] == int'(r);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) inFlight[i] = -1;
    mWaiting = 0; mErr = 0; mKilled = 0; mWaited = 0; mStalls = 0;
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input bit wr, input int wa, input bit jb, input bit macc, input bit rdy);
    id_valid = v; id_rs = 5'(rs); id_useRs = urs; id_rt = 5'(rt); id_useRt = urt;
    id_writeReg = wr; id_writeAddr = 5'(wa); id_jumpOrBranch = jb;
    mem_access = macc; MIO_ready = rdy;
  endtask

  // Called at a falling edge with inputs already driven: check this cycle's
  // outputs against the model, then let the model follow the rising edge.
  task automatic step(input string tag);
    logic [6:0]  expCtrl, gotCtrl;
    logic [31:0] expStall;
    #1;
    eFreeze = !MIO_ready && (mWaiting || mem_access);
    eRaw    = id_valid && ((id_useRs && producing(id_rs)) || (id_useRt && producing(id_rt)));
    eGo     = !eFreeze && !eRaw;
    eRed    = eGo && id_valid && id_jumpOrBranch;
    eFlush  = eRed && !DELAY_SLOT;
    eBub    = eRaw && !eFreeze;
    expCtrl  = {eFreeze, eGo, eGo, eFlush, eBub, eRed, mErr};
    expStall = 32'(mStalls);
    gotCtrl  = {pipe_freeze, pc_write_en, ifid_write_en, ifid_flush, idex_bubble, redirect_en, mem_timeout_err};
    {oPf, oPc, oIfw, oFl, oBub, oRed, oErr} = gotCtrl;
    oStall = stall_cycles;
    vectors++;
    $display("vec %0d %s ctrl=%b stall=%0d", vectors, tag, gotCtrl, stall_cycles);
    checks++;
    if (gotCtrl !== expCtrl) begin
      miscompares++;
      $display("FAIL ctrl[%s] got=%b want=%b (freeze,pc,ifid,flush,bubble,redirect,err)", tag, gotCtrl, expCtrl);
    end
    checks++;
    if (stall_cycles !== expStall) begin
      miscompares++;
      $display("FAIL stall[%s] got=%0d want=%0d", tag, stall_cycles, expStall);
    end
    @(posedge clk);
    if (!eGo && mStalls < 64'hFFFF_FFFF) mStalls++;
    if (!eFreeze) begin
      inFlight[2] = inFlight[1];
      inFlight[1] = inFlight[0];
      inFlight[0] = (id_valid && id_writeReg && !eRaw && !mKilled && id_writeAddr != 0) ? int'(id_writeAddr) : -1;
    end
    if (eGo) mKilled = eFlush;
    if (!mWaiting) begin
      if (mem_access && !MIO_ready) begin mWaiting = 1; mWaited = 0; end
    end else begin
      mWaited++;
      if (MIO_ready) mWaiting = 0;
      else if (mWaited == MEM_TIMEOUT) begin mWaiting = 0; mErr = 1; end
    end
    @(negedge clk);
  endtask

  task automatic pinIdleAfterReset(input string tag);
    pin({tag, "_pc"}, 32'(pc_write_en), 32'd1);
    pin({tag, "_ifid"}, 32'(ifid_write_en), 32'd1);
    pin({tag, "_others"}, 32'({pipe_freeze, ifid_flush, idex_bubble, redirect_en}), 32'd0);
    pin({tag, "_err"}, 32'(mem_timeout_err), 32'd0);
    pin({tag, "_stall"}, stall_cycles, 32'd0);
  endtask

  initial begin
    logic [4:0] ra;
    ra = REG_RA;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    modelReset();
    #2;
    pinIdleAfterReset("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: lw $2 then add $3,$2,$4 -> two bubbles, then issue
    drive(1, 1, 1, 2, 0, 1, 2, 0, 0, 1); step("lw");
    drive(1, 2, 1, 4, 1, 1, 3, 0, 0, 1); step("add0");
    pin("t1_bub0", 32'(oBub), 32'd1); pin("t1_pc0", 32'(oPc), 32'd0);
    step("add1");
    pin("t1_bub1", 32'(oBub), 32'd1);
    step("add2");
    pin("t1_bub2", 32'(oBub), 32'd0); pin("t1_pc2", 32'(oPc), 32'd1);
    pin("t1_stall", oStall, 32'd2);

    // 2: addi $5 then beq $5,$6 taken
    drive(1, 1, 1, 0, 0, 1, 5, 0, 0, 1); step("addi");
    drive(1, 5, 1, 6, 1, 0, 0, 1, 0, 1); step("beq0");
    pin("t2_red0", 32'(oRed), 32'd0);
    step("beq1");
    pin("t2_red1", 32'(oRed), 32'd0);
    step("beq2");
    pin("t2_red2", 32'(oRed), 32'd1); pin("t2_flush2", 32'(oFl), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("slot");
    pin("t2_flush3", 32'(oFl), 32'd0); pin("t2_stall", oStall, 32'd4);

    // 3: write $0 then read $0; jal/jr through $31
    drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 1); step("wr0");
    drive(1, 0, 1, 0, 1, 1, 8, 0, 0, 1); step("rd0");
    pin("t3_bub", 32'(oBub), 32'd0);
    drive(1, 0, 0, 0, 0, 1, int'(ra), 1, 0, 1); step("jal");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("jalslot");
    drive(1, int'(ra), 1, 0, 0, 0, 0, 1, 0, 1); step("jr0");
    pin("t3_jrbub", 32'(oBub), 32'd1);
    step("jr1");
    pin("t3_jrred", 32'(oRed), 32'd1);

    // 4: three not-ready cycles, ready on the fourth
    drive(1, 1, 1, 0, 0, 1, 7, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("mwait");
      pin("t4_freeze", 32'(oPf), 32'd1);
    end
    MIO_ready = 1'b1; step("mready");
    pin("t4_run", 32'(oPf), 32'd0); pin("t4_err", 32'(oErr), 32'd0);

    // 6: raw and freeze in the same cycle
    drive(1, 1, 1, 0, 0, 1, 9, 0, 0, 1); step("wr9");
    drive(1, 9, 1, 0, 0, 0, 0, 0, 1, 0); step("rd9frz");
    pin("t6_frz", 32'(oPf), 32'd1); pin("t6_nobub", 32'(oBub), 32'd0);
    MIO_ready = 1'b1; step("rd9rdy");
    pin("t6_bub", 32'(oBub), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step("idle");

    // ready arriving exactly on the last allowed wait cycle is a success
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MEM_TIMEOUT; i++) step("edge");
    MIO_ready = 1'b1; step("edgerdy");
    pin("edge_frz", 32'(oPf), 32'd0);
    mem_access = 1'b0; step("edgeidle");
    pin("edge_err", 32'(oErr), 32'd0);

    // 5: timeout, sticky error, reset mid-wait
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) step("tmo");
    pin("t5_err_pre", 32'(oErr), 32'd0);
    step("tmo_after");
    pin("t5_err", 32'(oErr), 32'd1);
    for (int i = 0; i < 5; i++) step("tmo_rewait");
    pin("t5_err_sticky", 32'(oErr), 32'd1);
    #2;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    modelReset();
    #1;
    pinIdleAfterReset("midreset");
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 1),
            $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 4), $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
